// File: rtl/q1_pkg.sv
// rtl/q1_pkg.sv - shared types and constants for the Q1-b sweep controller
package q1_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } sweep_state_t;

  localparam int IDX_W = 4;
  localparam int N_VEC = 16;

  // F = (A xor B) & (C | ~D), bit i is F for {A,B,C,D} = i
  localparam logic [N_VEC-1:0] Q1B_TRUTH = 16'h0DD0;

endpackage

// File: rtl/q1_sweep_ctrl.sv
// rtl/q1_sweep_ctrl.sv - exhaustive 16-vector sweep of the Q1-b unit with truth-table check
module q1_sweep_ctrl
  import q1_pkg::*;
#(
  parameter int unsigned      SETTLE_CYCLES = 1,
  parameter logic [N_VEC-1:0] EXPECTED      = Q1B_TRUTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             f_in,
  output logic [IDX_W-1:0] abcd,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_VEC-1:0] truth,
  output logic             fail_valid,
  output logic [IDX_W-1:0] fail_idx
);

  localparam logic [3:0]       SETTLE  = 4'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_VEC - 1);

  sweep_state_t     state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cnt;
  logic [N_VEC-1:0] truth_nxt;

  logic clr_run, load_vec, cnt_dec, sample_en, finish, abort_run;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = DRIVE;
      DRIVE:   state_nxt = (SETTLE != 4'd0) ? WAIT : SAMPLE;
      WAIT:    if (cnt <= 4'd1) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == IDX_MAX) ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // abort cancels any running state; in DONE it lands on the same edge anyway
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  always_comb begin
    clr_run   = 1'b0;
    load_vec  = 1'b0;
    cnt_dec   = 1'b0;
    sample_en = 1'b0;
    finish    = 1'b0;
    abort_run = abort && (state != IDLE);
    case (state)
      IDLE:    clr_run   = start && !abort;
      DRIVE:   load_vec  = !abort_run;
      WAIT:    cnt_dec   = !abort_run;
      SAMPLE:  sample_en = !abort_run;
      DONE:    finish    = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    truth_nxt      = truth;
    truth_nxt[idx] = f_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      abcd       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      truth      <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      idx        <= '0;
      cnt        <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      if (clr_run) begin
        idx        <= '0;
        abcd       <= '0;
        truth      <= '0;
        pass       <= 1'b0;
        fail_valid <= 1'b0;
        fail_idx   <= '0;
      end
      if (abort_run) begin
        abcd <= '0;
        pass <= 1'b0;
      end
      if (load_vec) begin
        abcd <= idx;
        cnt  <= SETTLE;
      end
      if (cnt_dec) cnt <= cnt - 4'd1;
      if (sample_en) begin
        truth <= truth_nxt;
        if (f_in != EXPECTED[idx] && !fail_valid) begin
          fail_valid <= 1'b1;
          fail_idx   <= idx;
        end
        // pass uses the merged table so it is already valid while done is high
        if (idx == IDX_MAX) pass <= (truth_nxt == EXPECTED);
        else                idx  <= idx + IDX_W'(1);
      end
      if (finish) abcd <= '0;
    end
  end

endmodule

// File: tb/tb_q1_sweep_ctrl.sv
// tb/tb_q1_sweep_ctrl.sv - self-checking bench for q1_sweep_ctrl at settle 0 and settle 1
module tb_q1_sweep_ctrl;
  import q1_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n[2];
  logic        start[2];
  logic        abort[2];
  logic        f_in[2];
  logic [3:0]  abcd[2];
  logic        busy[2];
  logic        done[2];
  logic        pass[2];
  logic [15:0] truth[2];
  logic        fail_valid[2];
  logic [3:0]  fail_idx[2];

  logic        stuck[2];
  logic [15:0] inv_mask[2];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  function automatic logic q1b(input logic [3:0] v);
    return (v[3] ^ v[2]) & (v[1] | ~v[0]);
  endfunction

  function automatic logic [15:0] golden_table();
    logic [15:0] t;
    for (int v = 0; v < 16; v++) t[v] = q1b(4'(v));
    return t;
  endfunction

  assign f_in[0] = stuck[0] ? 1'b0 : (q1b(abcd[0]) ^ inv_mask[0][abcd[0]]);
  assign f_in[1] = stuck[1] ? 1'b0 : (q1b(abcd[1]) ^ inv_mask[1][abcd[1]]);

  q1_sweep_ctrl #(.SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .abort(abort[0]), .f_in(f_in[0]),
    .abcd(abcd[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .truth(truth[0]),
    .fail_valid(fail_valid[0]), .fail_idx(fail_idx[0])
  );

  q1_sweep_ctrl #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .abort(abort[1]), .f_in(f_in[1]),
    .abcd(abcd[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .truth(truth[1]),
    .fail_valid(fail_valid[1]), .fail_idx(fail_idx[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  // Model: k = edges since the accepting edge; each vector occupies len = 2 + settle cycles
  typedef struct packed {
    logic [3:0]  abcd;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] truth;
    logic        fv;
    logic [3:0]  fi;
  } exp_t;

  function automatic exp_t model(input int k, input int len, input logic [15:0] fvec);
    exp_t        e;
    int          ns;
    logic [15:0] g;
    g      = Q1B_TRUTH;
    e      = '0;
    e.busy = (k <= 16 * len);
    e.abcd = (k >= 1 && k <= 16 * len) ? 4'((k - 1) / len) : 4'd0;
    e.done = (k == 16 * len);
    ns     = k / len;
    if (ns > 16) ns = 16;
    for (int v = 0; v < ns; v++) begin
      e.truth[v] = fvec[v];
      if (!e.fv && fvec[v] != g[v]) begin
        e.fv = 1'b1;
        e.fi = 4'(v);
      end
    end
    e.pass = (k >= 16 * len) && (e.truth == g);
    return e;
  endfunction

  int          mk[2];
  int          mka[2];
  bit          mrun[2];
  logic [15:0] mfvec[2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        mrun[d] <= 1'b0;
        mka[d]  <= -1;
        mk[d]   <= 0;
      end else if (mrun[d] && mka[d] < 0 && mk[d] <= 16 * (2 + d)) begin
        if (abort[d]) mka[d] <= mk[d];
        else          mk[d]  <= mk[d] + 1;
      end else if (start[d] && !abort[d]) begin
        mrun[d]  <= 1'b1;
        mk[d]    <= 0;
        mka[d]   <= -1;
        mfvec[d] <= stuck[d] ? 16'h0000 : (golden_table() ^ inv_mask[d]);
      end
    end
  end

  exp_t ce;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        if (!mrun[d]) begin
          ce = '0;
        end else if (mka[d] >= 0) begin
          ce      = model(mka[d], 2 + d, mfvec[d]);
          ce.abcd = 4'd0;
          ce.busy = 1'b0;
          ce.done = 1'b0;
          ce.pass = 1'b0;
        end else begin
          ce = model(mk[d], 2 + d, mfvec[d]);
        end
        chk("m_abcd",       d, 32'(abcd[d]),       32'(ce.abcd));
        chk("m_busy",       d, 32'(busy[d]),       32'(ce.busy));
        chk("m_done",       d, 32'(done[d]),       32'(ce.done));
        chk("m_pass",       d, 32'(pass[d]),       32'(ce.pass));
        chk("m_truth",      d, 32'(truth[d]),      32'(ce.truth));
        chk("m_fail_valid", d, 32'(fail_valid[d]), 32'(ce.fv));
        chk("m_fail_idx",   d, 32'(fail_idx[d]),   32'(ce.fi));
      end
    end
  end

  task automatic sweep(input int d, output int edges);
    @(posedge clk); #2 start[d] = 1'b1;
    @(posedge clk); #2 start[d] = 1'b0;
    @(negedge clk);
    chk("busy_after_start", d, 32'(busy[d]), 32'd1);
    edges = 0;
    while (done[d] !== 1'b1 && edges < 400) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic wait_abcd(input int d, input logic [3:0] v);
    int n = 0;
    while (abcd[d] !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_abcd_bound", d, 32'(n < 200), 32'd1);
  endtask

  initial begin
    int  n;
    bit  saw;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; start[d] = 1'b1; abort[d] = 1'b0;
      stuck[d] = 1'b0; inv_mask[d] = 16'h0000;
    end
    chk("golden_table", 0, 32'(golden_table()), 32'h0DD0);

    // 1: reset held with start high
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy",  d, 32'(busy[d]),  32'd0);
      chk("rst_truth", d, 32'(truth[d]), 32'd0);
      chk("rst_abcd",  d, 32'(abcd[d]),  32'd0);
    end
    @(posedge clk); #2;
    for (int d = 0; d < 2; d++) begin rst_n[d] = 1'b1; start[d] = 1'b0; end
    repeat (3) @(negedge clk);
    chk("idle_no_busy", 1, 32'(busy[1]), 32'd0);

    // 2: golden sweep, settle 1
    sweep(1, n);
    chk("t2_done_edges", 1, 32'(n), 32'd48);
    chk("t2_truth",      1, 32'(truth[1]), 32'h0DD0);
    chk("t2_pass",       1, 32'(pass[1]), 32'd1);
    chk("t2_fail_valid", 1, 32'(fail_valid[1]), 32'd0);
    @(negedge clk);
    chk("t2_abcd_after", 1, 32'(abcd[1]), 32'd0);
    chk("t2_busy_after", 1, 32'(busy[1]), 32'd0);

    // 3: f_in stuck at 0
    stuck[1] = 1'b1;
    sweep(1, n);
    chk("t3_truth",    1, 32'(truth[1]), 32'h0000);
    chk("t3_pass",     1, 32'(pass[1]), 32'd0);
    chk("t3_fv",       1, 32'(fail_valid[1]), 32'd1);
    chk("t3_fail_idx", 1, 32'(fail_idx[1]), 32'd4);
    stuck[1] = 1'b0;

    // 4: inverted idx 9, then idx 9 and 12
    inv_mask[1] = 16'h0200;
    sweep(1, n);
    chk("t4_truth",    1, 32'(truth[1]), 32'h0FD0);
    chk("t4_pass",     1, 32'(pass[1]), 32'd0);
    chk("t4_fail_idx", 1, 32'(fail_idx[1]), 32'd9);
    inv_mask[1] = 16'h1200;
    sweep(1, n);
    chk("t4b_truth",    1, 32'(truth[1]), 32'h1FD0);
    chk("t4b_fail_idx", 1, 32'(fail_idx[1]), 32'd9);
    inv_mask[1] = 16'h0000;

    // 5: start ignored while busy, abort at abcd = 6, then a clean sweep
    @(posedge clk); #2 start[1] = 1'b1;
    @(posedge clk); #2 start[1] = 1'b0;
    repeat (5) @(posedge clk);
    #2 start[1] = 1'b1;
    @(posedge clk); #2 start[1] = 1'b0;
    @(negedge clk);
    wait_abcd(1, 4'd6);
    abort[1] = 1'b1;
    @(posedge clk); #2 abort[1] = 1'b0;
    @(negedge clk);
    chk("t5_busy",  1, 32'(busy[1]), 32'd0);
    chk("t5_abcd",  1, 32'(abcd[1]), 32'd0);
    chk("t5_truth", 1, 32'(truth[1]), 32'h0010);
    saw = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done[1] === 1'b1) saw = 1'b1;
    end
    chk("t5_no_done", 1, 32'(saw), 32'd0);
    sweep(1, n);
    chk("t5_done_edges", 1, 32'(n), 32'd48);
    chk("t5_pass",       1, 32'(pass[1]), 32'd1);

    // 6: settle 0, start+abort together, then reset mid-sweep
    sweep(0, n);
    chk("t6_done_edges", 0, 32'(n), 32'd32);
    chk("t6_pass",       0, 32'(pass[0]), 32'd1);
    chk("t6_truth",      0, 32'(truth[0]), 32'h0DD0);
    @(posedge clk); #2 begin start[0] = 1'b1; abort[0] = 1'b1; end
    @(posedge clk); #2 begin start[0] = 1'b0; abort[0] = 1'b0; end
    @(negedge clk);
    chk("t6_abort_wins", 0, 32'(busy[0]), 32'd0);
    @(posedge clk); #2 start[0] = 1'b1;
    @(posedge clk); #2 start[0] = 1'b0;
    @(negedge clk);
    wait_abcd(0, 4'd10);
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk("t6_rst_abcd",  0, 32'(abcd[0]), 32'd0);
    chk("t6_rst_busy",  0, 32'(busy[0]), 32'd0);
    chk("t6_rst_truth", 0, 32'(truth[0]), 32'd0);
    chk("t6_rst_pass",  0, 32'(pass[0]), 32'd0);
    @(posedge clk); #2 rst_n[0] = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done[0] === 1'b1) saw = 1'b1;
    end
    chk("t6_no_done", 0, 32'(saw), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/q1_sweep_ctrl.md
Name: q1_sweep_ctrl

Overview:
Sequencer that exhaustively exercises the 4-input Q1-b combinational unit, F = (A xor B) & (C | ~D), and checks it.
- Drives all 16 {A,B,C,D} combinations in ascending order and waits a programmable settle time.
- Samples F and builds the 16-bit truth table.
- Compares against an expected table and reports pass/fail plus the first failing index.
- Sits between the board self-test logic (start/done handshake) and the unit's input pins.

Parameters:
- SETTLE_CYCLES, 1, wait cycles between driving a vector and sampling f_in; legal range 0..15.
- EXPECTED, 16'h0DD0, golden truth table; bit i = F for idx i, where {A,B,C,D} = idx[3:0] and A = MSB.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  synchronous cancel of a running sweep
- f_in  in  1  F output of the unit under control
- abcd  out  4  {A,B,C,D} drive to the unit (registered)
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle pulse, sweep complete
- pass  out  1  truth == EXPECTED; valid from done, held until next start
- truth  out  16  captured truth table
- fail_valid  out  1  at least one mismatch seen
- fail_idx  out  4  first mismatching idx (0 if none)

Behaviour:
- All outputs are registered.
- Reset (rst_n = 0 at a clk edge) sets state = IDLE and clears every output and internal counter to 0. This also applies mid-sweep.
- States: IDLE, DRIVE, WAIT, SAMPLE, DONE.
- IDLE:
  - If start = 1 and abort = 0: idx <= 0, abcd <= 0; clear truth, pass, fail_valid and fail_idx; busy <= 1; go to DRIVE.
  - If abort = 1: stay in IDLE.
- DRIVE:
  - abcd <= idx; load settle counter with SETTLE_CYCLES.
  - Next state is WAIT if SETTLE_CYCLES > 0, else SAMPLE.
- WAIT: decrement the counter each cycle; go to SAMPLE on the cycle the counter reaches 1.
- SAMPLE:
  - truth[idx] <= f_in.
  - If f_in != EXPECTED[idx] and fail_valid = 0: fail_valid <= 1, fail_idx <= idx. Later mismatches do not overwrite the first one.
  - If idx == 15, go to DONE; otherwise idx <= idx + 1 and go to DRIVE. idx never wraps.
- DONE:
  - done = 1 for exactly this one cycle; pass <= (final truth == EXPECTED), with the last SAMPLE write included.
  - abcd <= 0, busy <= 0, go to IDLE.
- Latency: each vector takes 2 + SETTLE_CYCLES cycles. DONE is entered 16*(2+SETTLE_CYCLES) edges after the edge that accepted start (48 with the default).
- start while busy: ignored, no queueing.
- abort in any state other than IDLE:
  - Next edge: IDLE, busy = 0, abcd = 0, pass = 0.
  - No done pulse.
  - truth, fail_valid and fail_idx keep the partial values.
- abort and start together in IDLE: abort wins.
- abort during DONE: the done pulse still occurs, because DONE exits on the same edge.
- f_in is assumed synchronous to clk; the settle time covers combinational delay only.

Decomposition:
- Package q1_pkg holds:
  - state enum sweep_state_t (IDLE, DRIVE, WAIT, SAMPLE, DONE)
  - IDX_W = 4, N_VEC = 16
  - constant Q1B_TRUTH = 16'h0DD0, the default for EXPECTED
- No sub-module: the settle counter and idx counter are small enough to stay inline.
- The bench instantiates the Q1-b combinational unit on abcd/f_in.

Test Plan:
1. Reset: hold rst_n = 0 for 3 cycles with start = 1 -> all outputs 0, state IDLE, no busy after release until a start.
2. Golden unit on f_in, SETTLE_CYCLES = 1, one-cycle start -> busy next edge; abcd steps 0..15; done exactly 48 edges after start; truth = 16'h0DD0, pass = 1, fail_valid = 0, abcd = 0 after done.
3. f_in stuck at 0 -> truth = 16'h0000, pass = 0, fail_valid = 1, fail_idx = 4.
4. Golden unit with idx 9 output inverted -> truth = 16'h0FD0, pass = 0, fail_idx = 9. Also invert idx 12 -> fail_idx stays 9.
5. Extra start pulses mid-sweep are ignored. abort while abcd = 6 -> next edge busy = 0, abcd = 0, no done pulse. Then a new start -> full sweep passes with done at 48 edges.
6. SETTLE_CYCLES = 0 -> done 32 edges after start, pass = 1. Second run with rst_n = 0 at idx 10 -> next edge all outputs 0, no done.
